sseg_scan_controller: RTL
=========================

SSEG_SCAN_CONTROLLER -- requirements
Module: sseg_scan_controller

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 12500, clk cycles each digit is driven per scan slot.
REQ-002 SHALL have parameter BLANK_CYCLES, default 64, clk cycles of all-anodes-off dead time after each slot.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port load_valid  input  1  new display value offered.
REQ-006 SHALL have port load_data  input  16  four hex digits; [3:0] digit 0 (rightmost) through [15:12] digit 3.
REQ-007 SHALL have port load_ready  output  1  shadow buffer free.
REQ-008 SHALL have port lz_en  input  1  leading-zero blanking enable.
REQ-009 SHALL have port brightness  input  3  PWM duty, 0 = 1/8 through 7 = 8/8.
REQ-010 SHALL have port sseg_anode  output  4  active-low digit enables.
REQ-011 SHALL have port sseg_cathode  output  8  active-low segments; [6:0] = g..a, [7] = dp.
REQ-012 SHALL have port digit_index  output  2  slot currently scanned.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 SHALL implement a two-state FSM, S_ON and S_BLANK, with a cycle counter and a 2-bit slot index.
REQ-015 S_ON SHALL last exactly ON_CYCLES cycles, then go to S_BLANK; S_BLANK SHALL last exactly BLANK_CYCLES cycles, then go to S_ON with index +1 mod 4 (3 wraps to 0).
REQ-016 One frame SHALL equal 4*(ON_CYCLES+BLANK_CYCLES) cycles.
REQ-017 In S_BLANK, sseg_anode SHALL be 4'hF and sseg_cathode SHALL be 8'hFF.
REQ-018 In S_ON, sseg_anode SHALL drive bit [index] low only when the free-running 3-bit pwm_cnt <= brightness, else 4'hF.
REQ-019 In S_ON, sseg_cathode SHALL carry the hex (0-F) glyph of active[4*index+3 : 4*index], with dp = 1.
REQ-020 When lz_en = 1, digit k (k = 3..1) SHALL be blanked (anode off, cathode 8'hFF) if it and every higher digit of active are zero; digit 0 SHALL never be blanked.
REQ-021 sseg_anode and sseg_cathode SHALL be registered; their values SHALL reflect the FSM state of the same cycle.
REQ-022 load_ready SHALL equal !pending, combinationally.
REQ-023 A transfer SHALL occur when load_valid && load_ready on a clock edge: shadow <= load_data, pending <= 1.
REQ-024 On the final S_BLANK cycle of slot 3, frame_done SHALL pulse high; if pending = 1, active <= shadow and pending <= 0 on the same edge.
REQ-025 Because load_ready = 0 while pending = 1, a load and a commit SHALL never coincide; a new transfer is possible from the cycle after the commit.
REQ-026 active SHALL change only at frame boundaries, never mid-frame.
REQ-027 load_valid with load_ready = 0 SHALL be ignored, with no state change.
REQ-028 brightness and lz_en SHALL be sampled every cycle; a change takes effect on the next edge.

Reset
REQ-029 While rst_n = 0: state = S_BLANK, index = 0, counters = 0, pwm_cnt = 0, active = 0, shadow = 0, pending = 0, sseg_anode = 4'hF, sseg_cathode = 8'hFF, frame_done = 0, load_ready = 1.
REQ-030 Reset asserted mid-frame or mid-transfer SHALL discard shadow and pending data immediately.
REQ-031 After release, the first S_ON slot SHALL begin after BLANK_CYCLES cycles.

Structure
REQ-032 Package sseg_pkg SHALL hold the state encoding, NUM_DIGITS = 4, and the ON_CYCLES/BLANK_CYCLES defaults.
REQ-033 Glyph lookup SHALL be the combinational sub-module sseg_hex_decoder (4-bit in, 7-bit active-low out), covering 0-F.

Verification (ON_CYCLES = 16, BLANK_CYCLES = 4)
REQ-034 Reset release, no load -> anodes F for 4 cycles, then digit 0 shows "0" (cathode 8'hC0); frame_done every 80 cycles.
REQ-035 Load 16'h1234, brightness = 7 -> value appears only after the next frame_done; slot 0 cathode 8'h99 ("4"), slot 3 cathode 8'hF9 ("1"); each slot anode low exactly 16 cycles.
REQ-036 Second load_valid one cycle after an accepted load -> load_ready = 0 and the value is ignored; load_ready returns to 1 the cycle after frame_done.
REQ-037 lz_en = 1, active = 16'h0070 -> anodes for slots 3 and 2 stay F; slot 1 shows "7", slot 0 shows "0".
REQ-038 brightness = 1 -> in S_ON the anode is low 2 of every 8 cycles.
REQ-039 rst_n pulsed low mid-slot 2 with pending = 1 -> outputs F/FF immediately, pending cleared, display returns to "0".

Source files
------------

// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
// Shared definitions for the four-digit seven-segment scan controller:
// scan FSM state encoding, digit count, default slot timing and the
// leading-zero blanking helper.
// -----------------------------------------------------------------------------
package sseg_pkg;

  localparam int NUM_DIGITS       = 4;
  localparam int ON_CYCLES_DEF    = 12500;
  localparam int BLANK_CYCLES_DEF = 64;

  typedef enum logic {
    S_ON    = 1'b0,
    S_BLANK = 1'b1
  } state_e;

  // A digit is suppressed when it and every more-significant digit are zero.
  // Digit 0 is never suppressed so a value of zero still shows "0".
  function automatic logic lz_blank(input logic [15:0] value, input logic [1:0] idx);
    case (idx)
      2'd3:    return (value[15:12] == 4'h0);
      2'd2:    return (value[15:8]  == 8'h00);
      2'd1:    return (value[15:4]  == 12'h000);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sseg_hex_decoder.sv
// -----------------------------------------------------------------------------
// sseg_hex_decoder
// Combinational hex (0-F) to seven-segment glyph lookup, active-low.
//   hex_i    : 4-bit digit value
//   seg_n_o  : segments {g,f,e,d,c,b,a}, 0 = segment lit
// -----------------------------------------------------------------------------
module sseg_hex_decoder (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    case (hex_i)
      4'h0: seg_n_o = 7'h40;
      4'h1: seg_n_o = 7'h79;
      4'h2: seg_n_o = 7'h24;
      4'h3: seg_n_o = 7'h30;
      4'h4: seg_n_o = 7'h19;
      4'h5: seg_n_o = 7'h12;
      4'h6: seg_n_o = 7'h02;
      4'h7: seg_n_o = 7'h78;
      4'h8: seg_n_o = 7'h00;
      4'h9: seg_n_o = 7'h10;
      4'hA: seg_n_o = 7'h08;
      4'hB: seg_n_o = 7'h03;
      4'hC: seg_n_o = 7'h46;
      4'hD: seg_n_o = 7'h21;
      4'hE: seg_n_o = 7'h06;
      default: seg_n_o = 7'h0E;  // F
    endcase
  end

endmodule

// File: rtl/sseg_scan_controller.sv
// -----------------------------------------------------------------------------
// sseg_scan_controller
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
// Each slot drives one digit for ON_CYCLES, then all anodes off for
// BLANK_CYCLES. A shadow buffer accepts new values at any time and is copied
// to the displayed value only at a frame boundary, so a frame never tears.
//   clk, rst_n         : clock, asynchronous active-low reset
//   load_valid/ready   : handshake for load_data (four hex digits, [3:0] = digit 0)
//   lz_en              : leading-zero blanking enable
//   brightness         : PWM duty, 0 = 1/8 ... 7 = 8/8
//   sseg_anode         : active-low digit enables (registered)
//   sseg_cathode       : active-low segments, [7] = dp (registered)
//   digit_index        : slot currently scanned
//   frame_done         : pulse on the last cycle of each frame
// -----------------------------------------------------------------------------
module sseg_scan_controller
  import sseg_pkg::*;
#(
  parameter int ON_CYCLES    = ON_CYCLES_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        lz_en,
  input  logic [2:0]  brightness,
  output logic [3:0]  sseg_anode,
  output logic [7:0]  sseg_cathode,
  output logic [1:0]  digit_index,
  output logic        frame_done
);

  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic              lead_q, lead_d;
  logic [2:0]        pwm_q, pwm_d;
  logic [15:0]       active_q, active_d;
  logic [15:0]       shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic [3:0]        anode_q, anode_d;
  logic [7:0]        cathode_q, cathode_d;

  logic              frame_end;
  logic              blank_d;
  logic [3:0]        digit_d;
  logic [6:0]        glyph_n;

  // The blank period right after reset is a lead-in, not the tail of slot 3:
  // it must neither advance the index nor count as a frame boundary.
  assign frame_end = (state_q == S_BLANK) && (cnt_q == BLANK_LAST) &&
                     (idx_q == 2'd3) && !lead_q;

  assign load_ready  = !pending_q;
  assign frame_done  = frame_end;
  assign digit_index = idx_q;
  assign sseg_anode  = anode_q;
  assign sseg_cathode = cathode_q;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    lead_d    = lead_q;
    pwm_d     = pwm_q + 3'd1;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    active_d  = active_q;

    case (state_q)
      S_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
          lead_d  = 1'b0;
          if (!lead_q) idx_d = idx_q + 2'd1;
        end
      end
    endcase

    // Load and commit cannot coincide: a load needs pending low, a commit
    // needs it high.
    if (load_valid && load_ready) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Outputs are computed from next-state values so the registered pins line
  // up with the FSM state they are registered alongside.
  assign digit_d = active_d[{idx_d, 2'b00} +: 4];

  sseg_hex_decoder u_decoder (
    .hex_i   (digit_d),
    .seg_n_o (glyph_n)
  );

  always_comb begin
    blank_d   = (state_d != S_ON) || (lz_en && lz_blank(active_d, idx_d));
    anode_d   = (blank_d || (pwm_d > brightness)) ? 4'hF : ~(4'b0001 << idx_d);
    cathode_d = blank_d ? 8'hFF : {1'b1, glyph_n};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BLANK;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      lead_q    <= 1'b1;
      pwm_q     <= 3'd0;
      active_q  <= 16'h0000;
      shadow_q  <= 16'h0000;
      pending_q <= 1'b0;
      anode_q   <= 4'hF;
      cathode_q <= 8'hFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      lead_q    <= lead_d;
      pwm_q     <= pwm_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

endmodule
